// File: rtl/dummy_done_monitor.sv
// dummy_done_monitor
//   Receiving end of the dummy IP's completion signalling. A start pulse arms
//   the monitor. It then waits for done_i or err_i from the dummy block and
//   reports PASS, or FAIL on an error or a timeout. It also reports the
//   elapsed cycle count, so integration checks can judge hardware state
//   rather than simulator messages.
//
// Ports
//   clk_i       in   1         clock, rising edge
//   rst_ni      in   1         asynchronous active-low reset
//   start_i     in   1         arm request (single-cycle pulse)
//   clear_i     in   1         PASS/FAIL -> IDLE, clears sticky flags
//   done_i      in   1         completion event from the dummy block
//   err_i       in   1         error event from the dummy block
//   busy_o      out  1         monitor armed
//   pass_o      out  1         completion seen
//   fail_o      out  1         error or timeout seen
//   timeout_o   out  1         FAIL came from timeout (sticky)
//   spurious_o  out  1         done_i/err_i seen while IDLE (sticky)
//   elapsed_o   out  CntWidth  armed-cycle count when the event was accepted
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; events here flag spurious_o
// ARMED | timer running, waiting for err_i / done_i / timeout
// PASS  | done_i accepted; sticky until start_i or clear_i
// FAIL  | err_i accepted or timer expired; sticky until start_i or clear_i

module dummy_done_monitor #(
  parameter int unsigned TimeoutCycles = 1000,
  parameter int unsigned CntWidth      = $clog2(TimeoutCycles)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                clear_i,
  input  logic                done_i,
  input  logic                err_i,
  output logic                busy_o,
  output logic                pass_o,
  output logic                fail_o,
  output logic                timeout_o,
  output logic                spurious_o,
  output logic [CntWidth-1:0] elapsed_o
);

  if (TimeoutCycles < 2) begin : g_param_chk
    $fatal(1, "dummy_done_monitor: TimeoutCycles must be >= 2");
  end

  localparam logic [CntWidth-1:0] TcLast = CntWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_PASS  = 2'b10,
    ST_FAIL  = 2'b11
  } state_e;

  state_e              r_state,    w_state_nxt;
  // Cycles left before timeout; loaded with TcLast on arm, expires at 0.
  logic [CntWidth-1:0] r_tmr,      w_tmr_nxt;
  logic [CntWidth-1:0] r_elapsed,  w_elapsed_nxt;
  logic                r_timeout,  w_timeout_nxt;
  logic                r_spurious, w_spurious_nxt;
  logic [CntWidth-1:0] w_cnt;

  // Up-count view of the down-counter: 0 in the first ARMED cycle.
  assign w_cnt = TcLast - r_tmr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_elapsed  <= '0;
      r_timeout  <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_elapsed  <= w_elapsed_nxt;
      r_timeout  <= w_timeout_nxt;
      r_spurious <= w_spurious_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = r_tmr;
    w_elapsed_nxt  = r_elapsed;
    w_timeout_nxt  = r_timeout;
    w_spurious_nxt = r_spurious;

    unique case (r_state)
      ST_IDLE: begin
        // An event in the same cycle as start_i is dropped and is not spurious.
        if (start_i) begin
          w_state_nxt    = ST_ARMED;
          w_tmr_nxt      = TcLast;
          w_elapsed_nxt  = '0;
          w_timeout_nxt  = 1'b0;
          w_spurious_nxt = 1'b0;
        end else if (done_i || err_i) begin
          w_spurious_nxt = 1'b1;
        end
      end

      ST_ARMED: begin
        // err beats done, and done beats an expiring timer.
        if (err_i) begin
          w_state_nxt   = ST_FAIL;
          w_elapsed_nxt = w_cnt;
        end else if (done_i) begin
          w_state_nxt   = ST_PASS;
          w_elapsed_nxt = w_cnt;
        end else if (r_tmr == '0) begin
          w_state_nxt   = ST_FAIL;
          w_timeout_nxt = 1'b1;
          w_elapsed_nxt = w_cnt;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end

      ST_PASS, ST_FAIL: begin
        if (start_i) begin
          w_state_nxt    = ST_ARMED;
          w_tmr_nxt      = TcLast;
          w_elapsed_nxt  = '0;
          w_timeout_nxt  = 1'b0;
          w_spurious_nxt = 1'b0;
        end else if (clear_i) begin
          w_state_nxt    = ST_IDLE;
          w_timeout_nxt  = 1'b0;
          w_spurious_nxt = 1'b0;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy_o     = (r_state == ST_ARMED);
  assign pass_o     = (r_state == ST_PASS);
  assign fail_o     = (r_state == ST_FAIL);
  assign timeout_o  = r_timeout;
  assign spurious_o = r_spurious;
  assign elapsed_o  = r_elapsed;

  // Simulation-only completion messages for the integration exercise.
  // ENABLE_DUMMY_VIP must stay undefined in synthesis builds.
`ifdef ENABLE_DUMMY_VIP
`ifndef DUMMY_SUCCESS_MESSAGE
`define DUMMY_SUCCESS_MESSAGE "dummy_done_monitor: PASS"
`endif
  always_ff @(posedge clk_i) begin
    if (rst_ni && r_state == ST_ARMED && w_state_nxt == ST_PASS)
      $info(`DUMMY_SUCCESS_MESSAGE);
    if (rst_ni && r_state == ST_ARMED && w_state_nxt == ST_FAIL)
      $error("dummy_done_monitor: dummy block reported error or timed out");
  end
`endif

endmodule

// File: tb/tb_dummy_done_monitor.sv
module tb_dummy_done_monitor;

  localparam int TC = 16;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       start_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       done_i  = 1'b0;
  logic       err_i   = 1'b0;
  logic       busy_o, pass_o, fail_o, timeout_o, spurious_o;
  logic [3:0] elapsed_o;

  dummy_done_monitor #(.TimeoutCycles(TC)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .clear_i    (clear_i),
    .done_i     (done_i),
    .err_i      (err_i),
    .busy_o     (busy_o),
    .pass_o     (pass_o),
    .fail_o     (fail_o),
    .timeout_o  (timeout_o),
    .spurious_o (spurious_o),
    .elapsed_o  (elapsed_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: outcome flags, plus the cycle index of the first armed
  // cycle. The running count is derived as (cycle - arm cycle).
  bit m_busy, m_pass, m_fail, m_to, m_sp;
  int m_el, m_arm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy_o",     32'(busy_o),     32'(m_busy));
    chk("pass_o",     32'(pass_o),     32'(m_pass));
    chk("fail_o",     32'(fail_o),     32'(m_fail));
    chk("timeout_o",  32'(timeout_o),  32'(m_to));
    chk("spurious_o", 32'(spurious_o), 32'(m_sp));
    chk("elapsed_o",  32'(elapsed_o),  32'(m_el));
  endtask

  task automatic model_reset();
    m_busy = 0; m_pass = 0; m_fail = 0; m_to = 0; m_sp = 0; m_el = 0; m_arm = 0;
  endtask

  task automatic model_arm();
    m_busy = 1; m_pass = 0; m_fail = 0; m_to = 0; m_sp = 0; m_el = 0;
    m_arm  = cyc + 1;
  endtask

  task automatic model_edge();
    int cnt;
    if (m_busy) begin
      cnt = cyc - m_arm;
      if (err_i) begin
        m_busy = 0; m_fail = 1; m_el = cnt;
      end else if (done_i) begin
        m_busy = 0; m_pass = 1; m_el = cnt;
      end else if (cnt == TC - 1) begin
        m_busy = 0; m_fail = 1; m_to = 1; m_el = cnt;
      end
    end else if (m_pass || m_fail) begin
      if (start_i) model_arm();
      else if (clear_i) begin
        m_pass = 0; m_fail = 0; m_to = 0; m_sp = 0;
      end
    end else begin
      if (start_i) model_arm();
      else if (done_i || err_i) m_sp = 1;
    end
  endtask

  task automatic step(input logic s, input logic c, input logic d, input logic e);
    start_i = s; clear_i = c; done_i = d; err_i = e;
    @(posedge clk_i);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic async_reset();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst_ni = 1'b1;

    // Quiet after reset.
    idle(50);

    // done_i at cnt=5 -> PASS, elapsed 5.
    step(1, 0, 0, 0);
    chk("busy_after_start", 32'(busy_o), 1);
    idle(5);
    chk("busy_before_done", 32'(busy_o), 1);
    step(0, 0, 1, 0);
    chk("pass_at_5", 32'(pass_o), 1);
    chk("elapsed_5", 32'(elapsed_o), 5);
    step(0, 1, 0, 0);

    // Timeout -> FAIL at cnt=15, then clear.
    step(1, 0, 0, 0);
    idle(15);
    chk("no_fail_before_tc", 32'(fail_o), 0);
    step(0, 0, 0, 0);
    chk("timeout_fail", 32'(fail_o), 1);
    chk("timeout_flag", 32'(timeout_o), 1);
    chk("timeout_elapsed", 32'(elapsed_o), 15);
    step(0, 1, 0, 0);
    chk("clear_timeout", 32'(timeout_o), 0);

    // done and err together at cnt=3 -> FAIL without timeout.
    step(1, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 1);
    chk("err_wins_fail", 32'(fail_o), 1);
    chk("err_wins_to", 32'(timeout_o), 0);
    chk("err_wins_el", 32'(elapsed_o), 3);

    // done exactly at cnt=15 beats the timeout.
    step(1, 0, 0, 0);
    idle(15);
    step(0, 0, 1, 0);
    chk("done_at_tc_pass", 32'(pass_o), 1);
    chk("done_at_tc_to", 32'(timeout_o), 0);
    step(0, 1, 0, 0);

    // A spurious done in IDLE sticks until start.
    step(0, 0, 1, 0);
    chk("spurious_set", 32'(spurious_o), 1);
    idle(4);
    step(1, 0, 0, 0);
    chk("spurious_cleared", 32'(spurious_o), 0);

    // Async reset at cnt=8.
    idle(8);
    async_reset();
    chk("reset_busy", 32'(busy_o), 0);

    // PASS with start+clear together re-arms.
    step(1, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0);
    step(1, 1, 0, 0);
    chk("start_beats_clear", 32'(busy_o), 1);
    idle(20);

    // start with event in IDLE: arm, no spurious.
    step(0, 1, 0, 0);
    step(1, 0, 1, 1);
    chk("start_evt_busy", 32'(busy_o), 1);
    chk("start_evt_nosp", 32'(spurious_o), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      else step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
